// File: rtl/square_bcd_disp.sv
// Binary-to-BCD converter (shift-and-add-3) for an 8-bit square result,
// driving three registered 7-segment digits with leading-zero blanking.
module square_bcd_disp #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_h,
    output logic [3:0] bcd_t,
    output logic [3:0] bcd_o,
    output logic [6:0] seg_h,
    output logic [6:0] seg_t,
    output logic [6:0] seg_o
);

    // state | meaning
    // IDLE  | waiting for start; results held
    // SHIFT | one add-3/shift step per cycle, eight cycles total
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_nxt;
    logic [7:0]  sh;
    logic [11:0] scratch;
    logic [2:0]  cnt;
    logic [11:0] adj;
    logic [19:0] shifted;
    logic [3:0]  fin_h, fin_t, fin_o;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d, input logic blank);
        logic [6:0] p;
        p = 7'b0000000;
        if (!blank) begin
            case (d)
                4'd0: p = 7'b0111111;
                4'd1: p = 7'b0000110;
                4'd2: p = 7'b1011011;
                4'd3: p = 7'b1001111;
                4'd4: p = 7'b1100110;
                4'd5: p = 7'b1101101;
                4'd6: p = 7'b1111101;
                4'd7: p = 7'b0000111;
                4'd8: p = 7'b1111111;
                4'd9: p = 7'b1101111;
                default: p = 7'b0000000;
            endcase
        end
        return SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    always_comb begin
        adj     = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
        shifted = {adj, sh} << 1;
        fin_h   = shifted[19:16];
        fin_t   = shifted[15:12];
        fin_o   = shifted[11:8];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == 3'd7) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh      <= 8'd0;
            scratch <= 12'd0;
            cnt     <= 3'd0;
            done    <= 1'b0;
            bcd_h   <= 4'd0;
            bcd_t   <= 4'd0;
            bcd_o   <= 4'd0;
            seg_h   <= enc(4'd0, 1'b1);
            seg_t   <= enc(4'd0, 1'b1);
            seg_o   <= enc(4'd0, 1'b0);
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sh      <= bin;
                    scratch <= 12'd0;
                    cnt     <= 3'd0;
                end
            end else begin
                sh      <= shifted[7:0];
                scratch <= shifted[19:8];
                cnt     <= cnt + 3'd1;
                // Final digits come straight from the combinational step so
                // they appear on the same edge that completes the eighth shift.
                if (cnt == 3'd7) begin
                    done  <= 1'b1;
                    bcd_h <= fin_h;
                    bcd_t <= fin_t;
                    bcd_o <= fin_o;
                    seg_h <= enc(fin_h, fin_h == 4'd0);
                    seg_t <= enc(fin_t, (fin_h == 4'd0) && (fin_t == 4'd0));
                    seg_o <= enc(fin_o, 1'b0);
                end
            end
        end
    end

endmodule

// File: tb/tb_square_bcd_disp.sv
// Directed bench for square_bcd_disp (active-low segments): latency, blanking,
// back-to-back starts, ignored starts, mid-conversion reset and a square sweep.
module tb_square_bcd_disp;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] bin;
    logic       busy, done;
    logic [3:0] bcd_h, bcd_t, bcd_o;
    logic [6:0] seg_h, seg_t, seg_o;

    int checks = 0;
    int failures = 0;

    logic [3:0] exp_h, exp_t, exp_o;
    logic [6:0] exp_sh, exp_st, exp_so;

    localparam logic [6:0] BLK = 7'b1111111;

    square_bcd_disp #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done),
        .bcd_h(bcd_h), .bcd_t(bcd_t), .bcd_o(bcd_o),
        .seg_h(seg_h), .seg_t(seg_t), .seg_o(seg_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [6:0] lo(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    task automatic chk_hold(input string tag);
        chk(tag, {bcd_h, bcd_t, bcd_o, seg_h, seg_t, seg_o},
            {exp_h, exp_t, exp_o, exp_sh, exp_st, exp_so});
    endtask

    task automatic start_conv(input logic [7:0] v);
        start = 1'b1;
        bin   = v;
        tick();
        start = 1'b0;
        bin   = ~v;
        chk("accept_busy", busy, 1'b1);
        chk("accept_done_low", done, 1'b0);
        chk_hold("accept_hold");
    endtask

    task automatic finish_conv(input logic [3:0] h, t, o, input logic [6:0] sh_e, st_e, so_e,
                               input bit glitch);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("shift_busy", busy, 1'b1);
            chk("shift_done_low", done, 1'b0);
            chk_hold("shift_hold");
            if (glitch && i == 3) begin
                start = 1'b1;
                bin   = 8'd16;
            end
            if (glitch && i == 4) start = 1'b0;
        end
        tick();
        chk("done_pulse", done, 1'b1);
        chk("done_busy_low", busy, 1'b0);
        exp_h = h; exp_t = t; exp_o = o;
        exp_sh = sh_e; exp_st = st_e; exp_so = so_e;
        chk_hold("result");
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bin = 8'(i * 37);
            tick();
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
            chk_hold("idle_hold");
        end
    endtask

    initial begin
        int v, h, t, o;
        logic [6:0] sh_e, st_e;

        rst = 1'b0; start = 1'b0; bin = 8'd0;
        exp_h = 4'd0; exp_t = 4'd0; exp_o = 4'd0;
        exp_sh = BLK; exp_st = BLK; exp_so = 7'b1000000;
        tick(); tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk_hold("reset_out");
        rst = 1'b1;
        idle_ticks(2);

        // 225 -> 2,2,5
        start_conv(8'd225);
        finish_conv(4'd2, 4'd2, 4'd5, 7'b0100100, 7'b0100100, 7'b0010010, 1'b0);
        idle_ticks(2);

        // 0 fully blanked except ones; 9 keeps tens blank
        start_conv(8'd0);
        finish_conv(4'd0, 4'd0, 4'd0, BLK, BLK, 7'b1000000, 1'b0);
        start_conv(8'd9);
        finish_conv(4'd0, 4'd0, 4'd9, BLK, BLK, 7'b0010000, 1'b0);

        // back-to-back: start asserted during the done cycle of 255
        start_conv(8'd255);
        finish_conv(4'd2, 4'd5, 4'd5, 7'b0100100, 7'b0010010, 7'b0010010, 1'b0);
        start_conv(8'd100);
        finish_conv(4'd1, 4'd0, 4'd0, 7'b1111001, 7'b1000000, 7'b1000000, 1'b0);
        idle_ticks(1);

        // start/bin change mid-conversion is ignored
        start_conv(8'd49);
        finish_conv(4'd0, 4'd4, 4'd9, BLK, 7'b0011001, 7'b0010000, 1'b1);
        idle_ticks(10);

        // reset during SHIFT cycle 5 aborts with no done
        start_conv(8'd144);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_pre_busy", busy, 1'b1);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_h = 4'd0; exp_t = 4'd0; exp_o = 4'd0;
        exp_sh = BLK; exp_st = BLK; exp_so = 7'b1000000;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk_hold("abort_out");
        idle_ticks(10);

        // squares 0..225
        for (int x = 0; x <= 15; x++) begin
            v = x * x;
            h = v / 100; t = (v / 10) % 10; o = v % 10;
            sh_e = (h == 0) ? BLK : lo(h);
            st_e = (h == 0 && t == 0) ? BLK : lo(t);
            start_conv(8'(v));
            finish_conv(4'(h), 4'(t), 4'(o), sh_e, st_e, lo(o), 1'b0);
        end
        idle_ticks(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/square_bcd_disp.md
SQUARE_BCD_DISP -- requirements
Module: square_bcd_disp

Interface
REQ-001 The block SHALL have parameter SEG_ACTIVE_LOW, default 1, meaning 1 = segment outputs active-low and 0 = active-high.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a request to convert bin; sampled on the rising edge of clk.
REQ-005 The block SHALL have port bin, input, 8, the unsigned binary value (square result, 0..225 nominal, 0..255 legal).
REQ-006 The block SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-007 The block SHALL have port done, output, 1, a one-cycle pulse marking new results on bcd_*/seg_*.
REQ-008 The block SHALL have ports bcd_h, bcd_t, bcd_o, output, 4 each, the hundreds, tens and ones BCD digits.
REQ-009 The block SHALL have ports seg_h, seg_t, seg_o, output, 7 each, the 7-segment patterns, bit order gfedcba.

Function
REQ-010 The FSM SHALL have two states: IDLE and SHIFT.
REQ-011 In IDLE with start=1, the block SHALL latch bin into an 8-bit shift register, clear the 12-bit BCD scratch and the 3-bit shift counter, and enter SHIFT.
REQ-012 In IDLE with start=0, the block SHALL hold all state and outputs.
REQ-013 Each SHIFT cycle SHALL first add 3 to every scratch digit >=5, then shift {scratch, shift register} left one bit, and increment the counter.
REQ-014 The block SHALL perform exactly 8 SHIFT cycles per conversion; after the 8th shift (counter wrap 7->0) it SHALL return to IDLE.
REQ-015 On the edge performing the 8th shift, the block SHALL load the final digits into bcd_h/t/o and the segment registers and set done=1 for exactly one cycle.
REQ-016 Latency SHALL be 8 clocks from the edge sampling start=1 to the first cycle with done=1.
REQ-017 busy SHALL be 1 exactly while the state is SHIFT.
REQ-018 start SHALL be ignored while busy=1; bin changes during SHIFT SHALL NOT affect the result.
REQ-019 start=1 in the cycle where done=1 (state is IDLE) SHALL be accepted, giving back-to-back conversions every 9 cycles.
REQ-020 bcd_* and seg_* SHALL hold their last values between done pulses and SHALL NOT change during SHIFT.
REQ-021 Digit-to-segment encoding (active-high, gfedcba) SHALL be: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-022 Leading-zero blanking SHALL apply: seg_h is blank when bcd_h=0, and seg_t is blank when bcd_h=0 and bcd_t=0; seg_o SHALL never be blank.
REQ-023 A blank digit SHALL be all segments off; with SEG_ACTIVE_LOW=1 every pattern, including blank, SHALL be bitwise inverted.
REQ-024 bcd_h SHALL never exceed 2, and bcd_t and bcd_o SHALL never exceed 9, for any 8-bit bin.

Reset
REQ-025 When rst=0 at a clock edge, the block SHALL set state to IDLE, clear the counter, shift register and scratch, and set busy=0, done=0 and bcd_h=bcd_t=bcd_o=0.
REQ-026 At reset, seg_h and seg_t SHALL be blank and seg_o SHALL show "0" (active-low: 1111111, 1111111, 1000000).
REQ-027 Reset SHALL take priority over start and SHALL abort an in-progress conversion with no done pulse.

Verification
REQ-028 bin=225, start pulse -> busy for 8 cycles, then done=1 for 1 cycle; bcd=2,2,5; seg (active-low) = 0100100, 0100100, 0010010.
REQ-029 bin=0 -> bcd=0,0,0; seg_h=seg_t=1111111, seg_o=1000000. Then bin=9 -> seg_t still blank, seg_o=0010000.
REQ-030 bin=255 then bin=100 back-to-back, with start held during the done cycle -> done pulses 9 cycles apart; results 2,5,5 then 1,0,0; the tens digit shows "0" (1000000), not blank.
REQ-031 Start bin=49; at cycle 3 of SHIFT drive start=1 with bin=16 -> ignored; result 0,4,9, with exactly one done pulse.
REQ-032 Start bin=144; assert rst=0 at SHIFT cycle 5 -> next cycle busy=0, done=0, outputs at reset values; no done pulse follows.
REQ-033 Sweep bin = x^2 for x=0..15 -> each result equals the decimal of x^2, and bcd_* and seg_* are stable throughout each SHIFT phase.
